// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the LC-3b instruction-fetch stage.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } if_fetch_state_t;

  localparam logic [15:0] LC3B_PC_INCR     = 16'd2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/if_fetch_unit.sv
// LC-3b IF stage: owns the PC, issues instruction reads, bypasses responses
// straight into IF/ID, parks one instruction under stall and squashes the
// in-flight read when a redirect lands mid-transaction.
module if_fetch_unit
  import if_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_plus2_out,
  output logic [15:0] if_instr_out,
  output logic        if_id_load
);

  if_fetch_state_t state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] hold_buf, hold_buf_n;
  logic [15:0] tgt, tgt_n;
  logic [15:0] rpc;
  logic [15:0] pc_plus2;

  // Instruction addresses are halfword aligned; drop bit 0 of the target.
  assign rpc      = {redirect_pc[15:1], 1'b0};
  assign pc_plus2 = pc + LC3B_PC_INCR;

  assign imem_address = pc;
  assign if_plus2_out = pc_plus2;

  // State, PC, hold buffer and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      hold_buf <= 16'h0000;
      tgt      <= 16'h0000;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      hold_buf <= hold_buf_n;
      tgt      <= tgt_n;
    end
  end

  // Next-state and output decode; redirect always outranks stall/delivery.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_buf_n   = hold_buf;
    tgt_n        = tgt;
    imem_read    = 1'b0;
    if_id_load   = 1'b0;
    if_instr_out = hold_buf;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_read = 1'b1;
        if (redirect_valid && imem_resp) begin
          pc_n = rpc;
        end else if (redirect_valid) begin
          // Read must complete at the old address; remember where to go.
          tgt_n   = rpc;
          state_n = DISCARD;
        end else if (imem_resp && !stall) begin
          if_instr_out = imem_rdata;
          if_id_load   = 1'b1;
          pc_n         = pc_plus2;
        end else if (imem_resp) begin
          hold_buf_n = imem_rdata;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = rpc;
          state_n = FETCH;
        end else if (!stall) begin
          if_id_load = 1'b1;
          pc_n       = pc_plus2;
          state_n    = FETCH;
        end
      end
      DISCARD: begin
        imem_read = 1'b1;
        if (imem_resp) begin
          pc_n    = redirect_valid ? rpc : tgt;
          state_n = FETCH;
        end else if (redirect_valid) begin
          tgt_n = rpc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; deliveries are scoreboarded, control
// outputs are checked inline each cycle.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] if_plus2_out;
  logic [15:0] if_instr_out;
  logic        if_id_load;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  if_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_plus2_out(if_plus2_out), .if_instr_out(if_instr_out),
    .if_id_load(if_id_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rsp, input logic [15:0] d, input logic st,
                       input logic rv, input logic [15:0] rp);
    imem_resp = rsp; imem_rdata = d; stall = st;
    redirect_valid = rv; redirect_pc = rp;
  endtask

  task automatic ctl(input string nm, input logic rd, input logic ld, input logic [15:0] addr);
    chk({nm, ".read"}, {15'd0, imem_read}, {15'd0, rd});
    chk({nm, ".load"}, {15'd0, if_id_load}, {15'd0, ld});
    chk({nm, ".addr"}, imem_address, addr);
  endtask

  // Monitor: every delivery must match the oldest expected {plus2, instr}.
  always @(negedge clk) begin
    if (rst_n && if_id_load) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h/%h expected no delivery", if_plus2_out, if_instr_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({if_plus2_out, if_instr_out} !== e) begin
          fails++;
          $display("FAIL sb_delivery: got %h/%h expected %h/%h",
                   if_plus2_out, if_instr_out, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    // Reset values
    @(negedge clk);
    ctl("rst", 1'b0, 1'b0, 16'h0000);
    chk("rst.plus2", if_plus2_out, 16'h0002);
    chk("rst.instr", if_instr_out, 16'h0000);
    next_cyc; rst_n = 1'b1;
    @(negedge clk); ctl("idle", 1'b0, 1'b0, 16'h0000);
    next_cyc;
    // 2-cycle memory, first fetch
    @(negedge clk); ctl("f0.c1", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0); exp_q.push_back({16'h0002, 16'h1234});
    @(negedge clk); ctl("f0.resp", 1'b1, 1'b1, 16'h0000);
    chk("f0.plus2", if_plus2_out, 16'h0002);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("f1.c1", 1'b1, 1'b0, 16'h0002);
    // Stall on response
    next_cyc; drive(1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0);
    @(negedge clk); ctl("st.resp", 1'b1, 1'b0, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      next_cyc; drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      @(negedge clk); ctl("st.hold", 1'b0, 1'b0, 16'h0002);
      chk("st.buf", if_instr_out, 16'hABCD);
    end
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0); exp_q.push_back({16'h0004, 16'hABCD});
    @(negedge clk); ctl("st.release", 1'b0, 1'b1, 16'h0002);
    next_cyc;
    @(negedge clk); ctl("st.next", 1'b1, 1'b0, 16'h0004);
    // Redirect one cycle before the response
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h3001);
    @(negedge clk); ctl("rd.req", 1'b1, 1'b0, 16'h0004);
    next_cyc; drive(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("rd.discard", 1'b1, 1'b0, 16'h0004);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("rd.tgt", 1'b1, 1'b0, 16'h3000);
    // Redirect coincident with response in FETCH
    next_cyc; drive(1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h5000);
    @(negedge clk); ctl("sim.fetch", 1'b1, 1'b0, 16'h3000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("sim.tgt", 1'b1, 1'b0, 16'h5000);
    // Redirect while holding a stalled instruction
    next_cyc; drive(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0);
    @(negedge clk); ctl("hr.resp", 1'b1, 1'b0, 16'h5000);
    next_cyc; drive(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFE);
    @(negedge clk); ctl("hr.redir", 1'b0, 1'b0, 16'h5000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("hr.tgt", 1'b1, 1'b0, 16'hFFFE);
    // PC wrap
    next_cyc; drive(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0); exp_q.push_back({16'h0000, 16'h7777});
    @(negedge clk); ctl("wrap.resp", 1'b1, 1'b1, 16'hFFFE);
    chk("wrap.plus2", if_plus2_out, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("wrap.next", 1'b1, 1'b0, 16'h0000);
    // Repeated redirects in DISCARD; same-cycle redirect wins over tgt
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h2000);
    @(negedge clk); ctl("dd.r1", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h2200);
    @(negedge clk); ctl("dd.r2", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("dd.wait", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b1, 16'h4444, 1'b0, 1'b1, 16'h2401);
    @(negedge clk); ctl("dd.resp", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("dd.tgt", 1'b1, 1'b0, 16'h2400);
    // Asynchronous reset during an outstanding read
    next_cyc; rst_n = 1'b0; #1;
    ctl("ar.async", 1'b0, 1'b0, 16'h0000);
    chk("ar.plus2", if_plus2_out, 16'h0002);
    chk("ar.instr", if_instr_out, 16'h0000);
    next_cyc; rst_n = 1'b1; drive(1'b1, 16'h9999, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("ar.idle", 1'b0, 1'b0, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("ar.fetch", 1'b1, 1'b0, 16'h0000);
    next_cyc; drive(1'b1, 16'h5678, 1'b0, 1'b0, 16'h0); exp_q.push_back({16'h0002, 16'h5678});
    @(negedge clk); ctl("ar.deliver", 1'b1, 1'b1, 16'h0000);
    next_cyc; drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(negedge clk); ctl("ar.next", 1'b1, 1'b0, 16'h0002);
    chk("sb.drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the LC-3b pipeline.
- Owns the PC and acts as initiator on the instruction-memory read interface.
- Produces the PC+2 and instruction pair that the IF/ID pipeline register captures, and drives that register's load strobe.
- Absorbs downstream stalls with a one-entry hold buffer.
- Handles branch/jump redirects, including a redirect that arrives while a memory read is outstanding.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_address  out  16  read address; always equals the current PC.
- imem_read  out  1  read request; held high, with address stable, until imem_resp.
- imem_resp  in  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  in  16  instruction word from memory.
- stall  in  1  downstream cannot accept an instruction this cycle.
- redirect_valid  in  1  one-cycle pulse: redirect fetch to redirect_pc.
- redirect_pc  in  16  redirect target; bit 0 is forced to 0 internally.
- if_plus2_out  out  16  PC of the delivered instruction + 2 (drives IF/ID PC input).
- if_instr_out  out  16  delivered instruction (drives IF/ID instruction input).
- if_id_load  out  1  IF/ID load strobe; high only in a delivery cycle.

Behaviour:
- Reset is asynchronous, active-low.
  - While rst_n=0: pc=RESET_PC, state=IDLE, hold buffer=0.
  - Resulting output values: imem_read=0, if_id_load=0, imem_address=RESET_PC, if_plus2_out=RESET_PC+2, if_instr_out=0.
- States: IDLE, FETCH, HOLD, DISCARD.
- imem_read=1 in FETCH and DISCARD only. Outputs are a combinational decode of state and inputs.
- imem_address=pc in every state. if_plus2_out=pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- IDLE: go to FETCH on the next cycle, unconditionally. First request is issued in the first cycle after rst_n deasserts.
- FETCH, with priority order:
  - redirect_valid=1 and imem_resp=1: discard the response (if_id_load=0); pc<=redirect_pc; stay in FETCH.
  - redirect_valid=1 and imem_resp=0: tgt<=redirect_pc; go to DISCARD. The read stays asserted at the old address.
  - imem_resp=1 and stall=0: zero-cycle bypass, delivering if_instr_out=imem_rdata with if_id_load=1; pc<=pc+2; stay in FETCH. The next request starts the following cycle with the new address, with imem_read kept high (back-to-back reads are legal).
  - imem_resp=1 and stall=1: buf<=imem_rdata; if_id_load=0; go to HOLD. pc is not advanced.
  - Otherwise: hold address and request.
- HOLD:
  - if_instr_out=buf, imem_read=0.
  - redirect_valid=1: drop buf; pc<=redirect_pc; go to FETCH; if_id_load=0.
  - stall=0: if_id_load=1; pc<=pc+2; go to FETCH.
  - stall=1: stay in HOLD.
- DISCARD:
  - The read at the old pc stays asserted until the response arrives.
  - A further redirect_valid overwrites tgt.
  - On imem_resp: the response is dropped; pc<=tgt, or redirect_pc if redirect_valid is high in the same cycle; go to FETCH.
  - if_id_load=0 throughout.
- if_instr_out outside delivery cycles: value is don't-care for function, but must be stable (equal to buf) in HOLD.
- redirect beats stall in every state. No instruction is delivered in a redirect cycle.
- Latency:
  - No stall: memory latency + 0 cycles, from request to if_id_load.
  - Throughput: one instruction per memory response.
- Reset mid-operation: immediate return to IDLE with reset values; the outstanding memory response is ignored.

Decomposition:
- Shared package if_fetch_pkg:
  - enum if_fetch_state_t {IDLE, FETCH, HOLD, DISCARD}
  - constant LC3B_PC_INCR=16'd2
  - default RESET_PC
- Single module; the hold buffer and target register are inline. No sub-module is needed.

Test Plan:
- Reset: RESET_PC=16'h0000 -> first cycle out of reset imem_read=0, then imem_read=1 with imem_address=0. With a 2-cycle memory returning 16'h1234: if_id_load=1, if_instr_out=16'h1234, if_plus2_out=16'h0002; next cycle imem_address=16'h0002.
- Stall: stall=1 when imem_resp carries 16'hABCD -> if_id_load=0, imem_read=0 for 3 stalled cycles, imem_address stays 16'h0002. When stall drops: if_id_load=1, if_instr_out=16'hABCD, if_plus2_out=16'h0004; next address 16'h0004.
- Redirect mid-read: redirect_valid=1, redirect_pc=16'h3001 one cycle before imem_resp -> the response is not loaded, the address is held until resp, and the next address is 16'h3000.
- Simultaneous events: redirect_valid with imem_resp in FETCH -> if_id_load=0 and next address is the redirect target. redirect_valid during HOLD -> buf is dropped, no load, fetch resumes at the target.
- Wrap: pc=16'hFFFE, response delivered -> if_plus2_out=16'h0000 and next imem_address=16'h0000.
- rst_n pulsed low during an outstanding read -> outputs return to their reset values asynchronously, and fetch restarts at RESET_PC.
